oled_cmd_sequencer: RTL and testbench

- Sequences SSD1306 command traffic onto the shared I2C byte engine that drives sck/sda.
- After power-up it waits, then streams the init command list, then serves button-driven blink requests by alternating the invert commands.
- Sits between the button conditioning logic and the I2C byte engine inside the top-level control block.

---
 rtl/oled_pkg.sv | 53 +++++
 rtl/oled_cmd_sequencer_if.sv | 20 ++
 rtl/oled_init_rom.sv | 21 ++
 rtl/oled_cmd_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_oled_cmd_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
// Shared types, SSD1306 command constants and the panel init list for the OLED command sequencer.
package oled_pkg;

   typedef enum logic [2:0] {
      PWRUP = 3'd0,
      INIT  = 3'd1,
      IDLE  = 3'd2,
      BLINK = 3'd3,
      RETRY = 3'd4,
      ERROR = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      BYTE_ADDR = 2'd0,
      BYTE_CTRL = 2'd1,
      BYTE_CMD  = 2'd2
   } byte_sel_t;

   typedef struct packed {
      logic [7:0] data;
      logic       start;
      logic       stop;
   } tx_byte_t;

   localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
   localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;
   localparam logic [7:0] CMD_NORMAL      = 8'hA6;
   localparam logic [7:0] CMD_INVERT      = 8'hA7;
   localparam logic [7:0] CTRL_CMD        = 8'h00;
   localparam logic [7:0] CMD_NOP         = 8'hE3;

   localparam int INIT_LIST_LEN = 25;

   // 128x64 panel bring-up: clocking, mux, offset, charge pump, addressing, scan, contrast, display on
   localparam logic [7:0] INIT_LIST [INIT_LIST_LEN] = '{
      8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
      8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
      8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
   };

   function automatic tx_byte_t frame_byte(input byte_sel_t sel, input logic [6:0] addr,
                                           input logic [7:0] cmd);
      tx_byte_t b;
      case (sel)
         BYTE_ADDR: b = '{data: {addr, 1'b0}, start: 1'b1, stop: 1'b0};
         BYTE_CTRL: b = '{data: CTRL_CMD, start: 1'b0, stop: 1'b0};
         BYTE_CMD:  b = '{data: cmd, start: 1'b0, stop: 1'b1};
         default:   b = '{data: CMD_NOP, start: 1'b0, stop: 1'b0};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/oled_cmd_sequencer_if.sv
// Byte-level handshake between the command sequencer and the I2C byte engine.
interface oled_cmd_sequencer_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_stop;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_ack;

   modport master (
      output tx_valid, tx_data, tx_start, tx_stop,
      input  tx_ready, tx_done, tx_ack
   );

   modport slave (
      input  tx_valid, tx_data, tx_start, tx_stop,
      output tx_ready, tx_done, tx_ack
   );
endinterface

// File: rtl/oled_init_rom.sv
// Combinational init-list lookup; out-of-range indices return a harmless NOP.
module oled_init_rom
   import oled_pkg::*;
#(
   parameter int IDX_W = 5
) (
   input  logic [IDX_W-1:0] idx,
   output logic [7:0]       cmd
);

   // Index to command byte
   always_comb begin
      cmd = CMD_NOP;
      if (int'(idx) < INIT_LIST_LEN) begin
         cmd = INIT_LIST[idx];
      end else begin
         cmd = CMD_NOP;
      end
   end

endmodule

// File: rtl/oled_cmd_sequencer.sv
// Drives SSD1306 command transactions (addr, control, command) onto the shared I2C byte engine:
// power-up delay, init list, then button-driven invert toggling with bounded NACK retries.
module oled_cmd_sequencer
   import oled_pkg::*;
#(
   parameter int         CLK_HZ     = 27_000_000,
   parameter int         POWERUP_US = 100,
   parameter logic [6:0] I2C_ADDR   = 7'h3C,
   parameter int         INIT_LEN   = INIT_LIST_LEN,
   parameter int         MAX_RETRY  = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        blink_req,
   oled_cmd_sequencer_if.master        bus,
   output logic                        init_done,
   output logic                        busy,
   output logic                        inverted,
   output logic                        error
);

   localparam int POWERUP_CYCLES = CLK_HZ / 1_000_000 * POWERUP_US;
   localparam int PWR_EFF        = (POWERUP_CYCLES > 1) ? POWERUP_CYCLES : 1;
   localparam int CNT_W          = (PWR_EFF > 1) ? $clog2(PWR_EFF) : 1;
   localparam int IDX_W          = $clog2(INIT_LEN + 1);
   localparam int RETRY_W        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [IDX_W-1:0]   idx_r;
   logic               pending_r;
   logic [RETRY_W-1:0] retry_r;
   byte_sel_t          sel_r;
   logic               wait_r;
   logic               tx_valid_r;
   tx_byte_t           tx_r;
   logic               init_done_r;
   logic               busy_r;
   logic               inverted_r;
   logic               error_r;

   logic [7:0]         rom_cmd_s;
   logic [7:0]         cmd_s;
   byte_sel_t          next_sel_s;

   oled_init_rom #(.IDX_W(IDX_W)) u_rom (
      .idx (idx_r),
      .cmd (rom_cmd_s)
   );

   // Command byte for the current transaction and the byte slot that follows the current one
   always_comb begin
      cmd_s      = rom_cmd_s;
      next_sel_s = BYTE_CMD;
      if (state_r == BLINK) begin
         if (inverted_r) begin
            cmd_s = CMD_NORMAL;
         end else begin
            cmd_s = CMD_INVERT;
         end
      end else begin
         cmd_s = rom_cmd_s;
      end
      if (sel_r == BYTE_ADDR) begin
         next_sel_s = BYTE_CTRL;
      end else begin
         next_sel_s = BYTE_CMD;
      end
   end

   // Sequencer FSM with registered handshake and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= PWRUP;
         cnt_r       <= '0;
         idx_r       <= '0;
         pending_r   <= 1'b0;
         retry_r     <= '0;
         sel_r       <= BYTE_ADDR;
         wait_r      <= 1'b0;
         tx_valid_r  <= 1'b0;
         tx_r        <= '0;
         init_done_r <= 1'b0;
         busy_r      <= 1'b0;
         inverted_r  <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         // Requests outside IDLE coalesce into one; IDLE consumes them directly below
         if (blink_req && (state_r != IDLE) && (state_r != ERROR)) begin
            pending_r <= 1'b1;
         end
         case (state_r)
            PWRUP: begin
               if (cnt_r == CNT_W'(PWR_EFF - 1)) begin
                  state_r    <= INIT;
                  busy_r     <= 1'b1;
                  sel_r      <= BYTE_ADDR;
                  tx_valid_r <= 1'b1;
                  tx_r       <= frame_byte(BYTE_ADDR, I2C_ADDR, cmd_s);
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            INIT, BLINK: begin
               if (tx_valid_r) begin
                  if (bus.tx_ready) begin
                     tx_valid_r <= 1'b0;
                     wait_r     <= 1'b1;
                  end
               end else if (wait_r && bus.tx_done) begin
                  wait_r <= 1'b0;
                  if (!bus.tx_ack) begin
                     state_r <= RETRY;
                  end else if (sel_r != BYTE_CMD) begin
                     sel_r      <= next_sel_s;
                     tx_valid_r <= 1'b1;
                     tx_r       <= frame_byte(next_sel_s, I2C_ADDR, cmd_s);
                  end else begin
                     retry_r <= '0;
                     if (state_r == BLINK) begin
                        inverted_r <= ~inverted_r;
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                     end else if (idx_r == IDX_W'(INIT_LEN - 1)) begin
                        idx_r       <= idx_r + IDX_W'(1);
                        init_done_r <= 1'b1;
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                     end else begin
                        idx_r      <= idx_r + IDX_W'(1);
                        sel_r      <= BYTE_ADDR;
                        tx_valid_r <= 1'b1;
                        tx_r       <= frame_byte(BYTE_ADDR, I2C_ADDR, cmd_s);
                     end
                  end
               end
            end
            IDLE: begin
               if (pending_r || blink_req) begin
                  pending_r  <= 1'b0;
                  state_r    <= BLINK;
                  busy_r     <= 1'b1;
                  sel_r      <= BYTE_ADDR;
                  tx_valid_r <= 1'b1;
                  tx_r       <= frame_byte(BYTE_ADDR, I2C_ADDR, cmd_s);
               end
            end
            RETRY: begin
               if (retry_r < RETRY_W'(MAX_RETRY)) begin
                  retry_r    <= retry_r + RETRY_W'(1);
                  state_r    <= init_done_r ? BLINK : INIT;
                  sel_r      <= BYTE_ADDR;
                  tx_valid_r <= 1'b1;
                  tx_r       <= frame_byte(BYTE_ADDR, I2C_ADDR, cmd_s);
               end else begin
                  state_r <= ERROR;
                  busy_r  <= 1'b0;
                  error_r <= 1'b1;
               end
            end
            ERROR: begin
               tx_valid_r <= 1'b0;
               busy_r     <= 1'b0;
               error_r    <= 1'b1;
            end
            default: begin
               state_r    <= ERROR;
               tx_valid_r <= 1'b0;
               busy_r     <= 1'b0;
               error_r    <= 1'b1;
            end
         endcase
      end
   end

   assign bus.tx_valid = tx_valid_r;
   assign bus.tx_data  = tx_r.data;
   assign bus.tx_start = tx_r.start;
   assign bus.tx_stop  = tx_r.stop;
   assign init_done    = init_done_r;
   assign busy         = busy_r;
   assign inverted     = inverted_r;
   assign error        = error_r;

endmodule

// File: tb/tb_oled_cmd_sequencer.sv
// Bench for oled_cmd_sequencer: I2C engine model, transaction-level expected-stream generator,
// a vector table of NACK/blink scenarios, hand-written corner sequences and randomized runs.
module tb_oled_cmd_sequencer;

   localparam int MAX_RETRY = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic blink_req = 1'b0;
   logic init_done, busy, inverted, error;

   oled_cmd_sequencer_if bus();

   oled_cmd_sequencer #(
      .CLK_HZ(1_000_000), .POWERUP_US(10), .I2C_ADDR(7'h3C), .INIT_LEN(25), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .blink_req(blink_req), .bus(bus),
      .init_done(init_done), .busy(busy), .inverted(inverted), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       start;
      logic [7:0] data;
      logic       stop;
   } rec_t;

   typedef struct {
      string name;
      int    nack0;
      int    nack1;
      int    blinks;
      int    exp_len;
      bit    exp_inv;
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   rec_t log_q[$];
   rec_t exp_q[$];
   bit   nack_map [0:511];
   bit   nack_all = 1'b0;
   int   ready_mode = 0;
   bit   rand_lat = 1'b0;
   logic eng_pend, eng_ack;
   int   lat, acc_cnt;

   logic [7:0] init_list [25] = '{
      8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
      8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
      8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
   };

   // I2C byte engine: accepts on valid&&ready, completes after a latency, ACK per nack policy
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_pend     <= 1'b0;
         eng_ack      <= 1'b0;
         lat          <= 0;
         acc_cnt      <= 0;
         bus.tx_done  <= 1'b0;
         bus.tx_ack   <= 1'b0;
         bus.tx_ready <= 1'b0;
      end else begin
         bus.tx_done <= 1'b0;
         case (ready_mode)
            0:       bus.tx_ready <= 1'b1;
            1:       bus.tx_ready <= ($urandom_range(0, 2) != 0);
            default: bus.tx_ready <= 1'b0;
         endcase
         if (eng_pend) begin
            if (lat == 0) begin
               bus.tx_done <= 1'b1;
               bus.tx_ack  <= eng_ack;
               eng_pend    <= 1'b0;
            end else begin
               lat <= lat - 1;
            end
         end else if (bus.tx_valid && bus.tx_ready) begin
            eng_pend <= 1'b1;
            lat      <= rand_lat ? int'($urandom_range(0, 3)) : 0;
            eng_ack  <= !(nack_all || nack_map[acc_cnt]);
            acc_cnt  <= acc_cnt + 1;
            log_q.push_back(rec_t'({bus.tx_start, bus.tx_data, bus.tx_stop}));
         end
      end
   end

   // Protocol monitor: held byte stays stable while stalled, and no byte is offered mid-flight
   initial begin
      logic pv, pr, ps, pt;
      logic [7:0] pd;
      pv = 1'b0; pr = 1'b0; ps = 1'b0; pt = 1'b0; pd = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (rst_n) begin
            if (pv && !pr) begin
               checks++;
               if (!(bus.tx_valid && bus.tx_data == pd && bus.tx_start == ps && bus.tx_stop == pt)) begin
                  errors++;
                  $display("FAIL hold_stable: got v=%0b d=%h required v=1 d=%h", bus.tx_valid, bus.tx_data, pd);
               end
            end
            if (bus.tx_valid) begin
               checks++;
               if (eng_pend) begin
                  errors++;
                  $display("FAIL offer_while_busy: got tx_valid=1 with byte in flight, required 0");
               end
            end
         end
         pv = rst_n && bus.tx_valid;
         pr = bus.tx_ready;
         pd = bus.tx_data;
         ps = bus.tx_start;
         pt = bus.tx_stop;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      blink_req = 1'b0;
      log_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic clear_nacks();
      for (int i = 0; i < 512; i++) nack_map[i] = 1'b0;
   endtask

   task automatic pulse_blink();
      @(negedge clk);
      blink_req = 1'b1;
      @(negedge clk);
      blink_req = 1'b0;
   endtask

   // Transaction-level reference: each command is addr/ctrl/cmd, a NACK aborts and retries it
   task automatic build_expected(input int n_blinks, output bit exp_err, output bit exp_inv,
                                 output bit exp_done);
      int pos;
      bit inv;
      exp_q.delete();
      pos = 0; inv = 1'b0; exp_err = 1'b0; exp_done = 1'b0;
      for (int c = 0; c < 25 + n_blinks && !exp_err; c++) begin
         logic [7:0] cmd;
         int tries;
         bit ok;
         cmd = (c < 25) ? init_list[c] : (inv ? 8'hA6 : 8'hA7);
         tries = 0; ok = 1'b0;
         while (!ok && !exp_err) begin
            bit nacked;
            nacked = 1'b0;
            for (int b = 0; b < 3 && !nacked; b++) begin
               rec_t r;
               if (b == 0) r = '{start: 1'b1, data: 8'h78, stop: 1'b0};
               else if (b == 1) r = '{start: 1'b0, data: 8'h00, stop: 1'b0};
               else r = '{start: 1'b0, data: cmd, stop: 1'b1};
               exp_q.push_back(r);
               if (nack_all || nack_map[pos]) nacked = 1'b1;
               pos++;
            end
            if (!nacked) ok = 1'b1;
            else begin
               tries++;
               if (tries > MAX_RETRY) exp_err = 1'b1;
            end
         end
         if (ok && c >= 25) inv = !inv;
         if (ok && c == 24) exp_done = 1'b1;
      end
      exp_inv = inv;
   endtask

   task automatic compare_stream(input string name);
      int bad;
      bad = 0;
      check({name, "_len"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         if (log_q[i] !== exp_q[i]) begin
            if (bad == 0) $display("FAIL %s_stream byte %0d: got %h required %h", name, i, log_q[i], exp_q[i]);
            bad++;
         end
      end
      checks++;
      if (bad != 0) errors++;
   endtask

   task automatic run_scenario(input int n_blinks);
      bit ok;
      do_reset();
      ok = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         @(posedge clk); #1;
         if (init_done || error) begin ok = 1'b1; break; end
      end
      check("init_wait", ok, 1);
      for (int b = 0; b < n_blinks; b++) begin
         if (error) break;
         pulse_blink();
         ok = 1'b0;
         for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (!busy) begin ok = 1'b1; break; end
         end
         check("blink_wait", ok, 1);
      end
      repeat (20) @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t vecs[6];
      bit   e_err, e_inv, e_done, ok;
      int   n, dones;

      vecs[0] = '{"plain",       -1, -1, 0, 75, 1'b0};
      vecs[1] = '{"nack_cmd5",   15, 16, 0, 77, 1'b0};
      vecs[2] = '{"blink1",      -1, -1, 1, 78, 1'b1};
      vecs[3] = '{"blink2",      -1, -1, 2, 81, 1'b0};
      vecs[4] = '{"blink_nack",  76, -1, 1, 80, 1'b1};
      vecs[5] = '{"nack_byte2",   2,  5, 0, 81, 1'b0};
      clear_nacks();

      // Reset state and power-up latency
      #3;
      check("rst_outputs", {bus.tx_valid, bus.tx_start, bus.tx_stop, bus.tx_data, init_done, busy, inverted, error}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.tx_valid) begin n = i; break; end
      end
      check("pwrup_cycles", n, 10);
      check("first_byte", {bus.tx_start, bus.tx_data, bus.tx_stop}, {1'b1, 8'h78, 1'b0});
      check("busy_init", busy, 1);
      dones = 0; ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (init_done) begin ok = 1'b1; break; end
         if (bus.tx_done) dones++;
      end
      check("init_done_seen", ok, 1);
      check("dones_at_init_done", dones, 75);
      check("busy_falls_with_init_done", busy, 0);
      check("bytes_at_init_done", log_q.size(), 75);
      check("first_cmd", log_q[2].data, 8'hAE);
      check("last_cmd", log_q[74].data, 8'hAF);

      // Vector table
      for (int v = 0; v < 6; v++) begin
         clear_nacks();
         if (vecs[v].nack0 >= 0) nack_map[vecs[v].nack0] = 1'b1;
         if (vecs[v].nack1 >= 0) nack_map[vecs[v].nack1] = 1'b1;
         run_scenario(vecs[v].blinks);
         build_expected(vecs[v].blinks, e_err, e_inv, e_done);
         compare_stream(vecs[v].name);
         check({vecs[v].name, "_len_table"}, log_q.size(), vecs[v].exp_len);
         check({vecs[v].name, "_inverted"}, inverted, vecs[v].exp_inv);
         check({vecs[v].name, "_error"}, error, 0);
         check({vecs[v].name, "_init_done"}, init_done, 1);
      end
      clear_nacks();

      // Coalescing: three requests during INIT produce one blink
      do_reset();
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (log_q.size() >= 10) begin ok = 1'b1; break; end
      end
      check("coal_reach_init", ok, 1);
      repeat (3) begin pulse_blink(); repeat (4) @(negedge clk); end
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (init_done && busy) begin ok = 1'b1; break; end
      end
      check("coal_blink_started", ok, 1);
      repeat (60) @(posedge clk);
      #1;
      check("coal_bytes", log_q.size(), 78);
      check("coal_cmd", log_q[77].data, 8'hA7);
      check("coal_inverted", inverted, 1);

      // Request in the same cycle as a blink completion queues exactly one more blink
      do_reset();
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (init_done) begin ok = 1'b1; break; end
      end
      pulse_blink();
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (bus.tx_done && log_q.size() == 78) begin ok = 1'b1; break; end
      end
      check("same_cycle_done_seen", ok, 1);
      check("same_cycle_busy", busy, 1);
      pulse_blink();
      repeat (100) @(posedge clk);
      #1;
      check("same_cycle_bytes", log_q.size(), 81);
      check("same_cycle_cmd2", log_q[80].data, 8'hA6);
      check("same_cycle_inverted", inverted, 0);

      // Every byte NACKed: 1+MAX_RETRY attempts then sticky error
      nack_all = 1'b1;
      do_reset();
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (error) begin ok = 1'b1; break; end
      end
      check("err_seen", ok, 1);
      pulse_blink();
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (bus.tx_valid) n++;
      end
      check("err_no_valid", n, 0);
      check("err_attempts", log_q.size(), 1 + MAX_RETRY);
      check("err_sticky", {error, busy, init_done}, 3'b100);
      nack_all = 1'b0;

      // Reset mid-byte clears outputs at once and restarts at PWRUP
      run_scenario(1);
      check("midrst_pre_inverted", inverted, 1);
      ready_mode = 2;
      pulse_blink();
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.tx_valid) begin ok = 1'b1; break; end
      end
      check("midrst_valid_seen", ok, 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_outputs", {bus.tx_valid, bus.tx_start, bus.tx_stop, bus.tx_data, init_done, busy, inverted, error}, 0);
      ready_mode = 0;
      log_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.tx_valid) begin n = i; break; end
      end
      check("midrst_pwrup_cycles", n, 10);
      check("midrst_first_byte", {bus.tx_start, bus.tx_data}, {1'b1, 8'h78});

      // Randomized backpressure, latency, sparse NACKs and blink counts against the reference
      ready_mode = 1;
      rand_lat = 1'b1;
      for (int r = 0; r < 4; r++) begin
         int nb;
         clear_nacks();
         for (int i = 0; i < 512; i++) nack_map[i] = ($urandom_range(0, 9) == 0);
         nb = int'($urandom_range(0, 3));
         run_scenario(nb);
         build_expected(nb, e_err, e_inv, e_done);
         compare_stream("rand");
         check("rand_inverted", inverted, e_inv);
         check("rand_error", error, e_err);
         check("rand_init_done", init_done, e_done);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
